hog_cell_hist_ctrl: RTL and testbench

HOG_CELL_HIST_CTRL -- requirements
Module: hog_cell_hist_ctrl

---
 rtl/hog_cell_hist_ctrl.sv | 122 ++++++++++++
 tb/tb_hog_cell_hist_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_cell_hist_ctrl.sv
// HOG cell histogram: accumulates CELL_PIX (code, mag) samples into 9 orientation bins,
// then streams the 9 bins out. Define HOG_HIST_SAT_EN to saturate bins instead of wrapping.
module hog_cell_hist_ctrl #(
    parameter int MAG_W    = 12,
    parameter int ACC_W    = 16,
    parameter int CELL_PIX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [3:0]       code,
    input  logic [MAG_W-1:0] mag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [3:0]       o_bin_idx,
    output logic [ACC_W-1:0] o_bin_val,
    output logic             o_last
);

    // Handshake: a sample moves on a rising edge with i_valid && i_ready, a bin moves with
    // o_valid && o_ready; o_valid/payload hold until taken, and clr overrides both transfers.
    localparam int CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
    localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q [9];
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;

    logic [3:0]       bin_sel;
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] drain_val;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] acc_add;
    logic             in_fire, out_fire, cell_done, last_bin;

    assign in_fire   = i_valid && (state_q == ST_ACCUM);
    assign out_fire  = o_ready && (state_q == ST_DRAIN);
    assign cell_done = in_fire && (cnt_q == CNT_W'(CELL_PIX - 1));
    assign last_bin  = (idx_q == 4'd8);

    // Codes above 8 fold into the last bin.
    always_comb begin
        bin_sel   = (code > 4'd8) ? 4'd8 : code;
        acc_cur   = '0;
        drain_val = '0;
        for (int b = 0; b < 9; b++) begin
            if (bin_sel == 4'(b)) acc_cur = acc_q[b];
            if (idx_q == 4'(b))   drain_val = acc_q[b];
        end
        sum = SUM_W'(acc_cur) + SUM_W'(mag);
`ifdef HOG_HIST_SAT_EN
        acc_add = (|sum[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_ACCUM;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: if (cell_done)           state_d = ST_DRAIN;
                ST_DRAIN: if (out_fire && last_bin) state_d = ST_ACCUM;
                default:                           state_d = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        i_ready   = (state_q == ST_ACCUM);
        o_valid   = (state_q == ST_DRAIN);
        o_bin_idx = o_valid ? idx_q : 4'd0;
        o_bin_val = o_valid ? drain_val : '0;
        o_last    = o_valid && last_bin;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 9; b++) acc_q[b] <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else if (clr) begin
            for (int b = 0; b < 9; b++) acc_q[b] <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else if (in_fire) begin
            for (int b = 0; b < 9; b++) begin
                if (bin_sel == 4'(b)) acc_q[b] <= acc_add;
            end
            if (cell_done) begin
                cnt_q <= '0;
                idx_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (out_fire) begin
            // The final bin transfer leaves the accumulators empty for the next cell.
            if (last_bin) begin
                for (int b = 0; b < 9; b++) acc_q[b] <= '0;
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hog_cell_hist_ctrl.sv
// Bench for hog_cell_hist_ctrl: directed cells checked against a bin-sum model and literals.
// Build with HOG_HIST_SAT_EN defined to check the saturating variant.
module tb_hog_cell_hist_ctrl;

    localparam int MAG_W    = 12;
    localparam int ACC_W    = 16;
    localparam int CELL_PIX = 64;
    localparam int EXP_W    = 4 + ACC_W + 1;
    localparam int ACC_MAX  = (1 << ACC_W) - 1;
`ifdef HOG_HIST_SAT_EN
    localparam int SAT_EXP = 'hFFFF;
`else
    localparam int SAT_EXP = 'hFFC0;
`endif

    logic             clk, rst, clr, i_valid, i_ready, o_valid, o_ready, o_last;
    logic [3:0]       code, o_bin_idx;
    logic [MAG_W-1:0] mag;
    logic [ACC_W-1:0] o_bin_val;

    hog_cell_hist_ctrl #(.MAG_W(MAG_W), .ACC_W(ACC_W), .CELL_PIX(CELL_PIX)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .i_valid(i_valid), .i_ready(i_ready), .code(code), .mag(mag),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_bin_idx(o_bin_idx), .o_bin_val(o_bin_val), .o_last(o_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // ---------------- model: per-cell bin sums ----------------
    logic [EXP_W-1:0] exp_q[$];
    int hist[9];
    int n_in = 0;
    int cell_start[8];
    int cell_no = 0;

    function automatic int fold(input int s);
`ifdef HOG_HIST_SAT_EN
        return (s > ACC_MAX) ? ACC_MAX : s;
`else
        return s % (ACC_MAX + 1);
`endif
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 9; b++) hist[b] = 0;
        n_in = 0;
    endtask

    task automatic model_add(input int c, input int m);
        hist[(c > 8) ? 8 : c] += m;
        n_in++;
        if (n_in == CELL_PIX) begin
            for (int b = 0; b < 9; b++)
                exp_q.push_back({4'(b), ACC_W'(fold(hist[b])), (b == 8)});
            model_reset();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int c, input int m);
        int waited = 0;
        code    = 4'(c);
        mag     = MAG_W'(m);
        i_valid = 1'b1;
        @(negedge clk);
        while (!i_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!i_ready) begin
            fail_now("send_wait");
            return;
        end
        if (n_in == 0) begin
            cell_start[cell_no % 8] = cyc;
            cell_no++;
        end
        @(posedge clk);
        #1;
        model_add(c, m);
    endtask

    task automatic wait_drained();
        int k = 0;
        while ((exp_q.size() != 0 || o_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || o_valid) fail_now("drain_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bin(input int idx);
        int k = 0;
        @(negedge clk);
        while (!(o_valid && o_bin_idx == 4'(idx)) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!(o_valid && o_bin_idx == 4'(idx))) fail_now("bin_wait");
    endtask

    // ---------------- scoreboard / compare process ----------------
    int got_val[16];
    int drain_cnt, last_cnt, drain_cyc, stall3;
    int first_valid_cyc = -1;
    logic prev_valid = 1'b0;

    task automatic clear_stats();
        for (int b = 0; b < 16; b++) got_val[b] = -1;
        drain_cnt = 0;
        last_cnt  = 0;
        drain_cyc = 0;
        stall3    = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("i_ready_not_o_valid", i_ready, !o_valid);
            if (o_valid) begin
                drain_cyc++;
                if (!prev_valid) first_valid_cyc = cyc;
                if (!o_ready && o_bin_idx == 4'd3) stall3++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bin: actual idx=%0d val=%0d required=no bin", o_bin_idx, o_bin_val);
                end else begin
                    chk("bin_idx", o_bin_idx, exp_q[0][EXP_W-1 -: 4]);
                    chk("bin_val", o_bin_val, exp_q[0][ACC_W:1]);
                    chk("bin_last", o_last, exp_q[0][0]);
                    if (o_ready) begin
                        got_val[o_bin_idx] = o_bin_val;
                        drain_cnt++;
                        if (o_last) last_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("o_last_idle", o_last, 0);
            end
            prev_valid = o_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b0; clr = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        code = 4'd0; mag = '0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_i_ready", i_ready, 1);
        chk("rst_o_last", o_last, 0);
        chk("rst_bin_idx", o_bin_idx, 0);
        chk("rst_bin_val", o_bin_val, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Uniform cell at full rate, followed back-to-back by a mixed-code cell.
        for (int i = 0; i < CELL_PIX; i++) send(2, 10);
        send(12, 1);
        chk("t1_bin2", got_val[2], 640);
        chk("t1_bin0", got_val[0], 0);
        chk("t1_bin8", got_val[8], 0);
        chk("t1_bins_moved", drain_cnt, 9);
        chk("t1_last_count", last_cnt, 1);
        chk("t1_drain_cycles", drain_cyc, 9);
        chk("t1_latency", first_valid_cyc - cell_start[0], CELL_PIX);
        chk("cell_period", cell_start[1] - cell_start[0], CELL_PIX + 9);
        clear_stats();
        for (int i = 1; i < 32; i++) send(12, 1);
        for (int i = 0; i < 32; i++) send(4, 3);
        i_valid = 1'b0;
        wait_drained();
        chk("t4_bin8", got_val[8], 32);
        chk("t4_bin4", got_val[4], 96);

        // Backpressure: hold bin 3 for five cycles.
        clear_stats();
        o_ready = 1'b0;
        for (int i = 0; i < CELL_PIX; i++) send(i % 9, i + 1);
        i_valid = 1'b0;
        wait_bin(0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) repeat (5) begin
                @(posedge clk);
                #1;
            end
            o_ready = 1'b1;
            @(posedge clk);
            #1;
            o_ready = 1'b0;
        end
        o_ready = 1'b1;
        wait_drained();
        chk("t2_bin3", got_val[3], 217);
        chk("t2_bin8", got_val[8], 252);
        chk("t2_stall_cycles", stall3, 5);
        chk("t2_bins_moved", drain_cnt, 9);

        // Large magnitudes: wrap or saturate.
        clear_stats();
        for (int i = 0; i < CELL_PIX; i++) send(0, 4095);
        i_valid = 1'b0;
        wait_drained();
        chk("t3_bin0", got_val[0], SAT_EXP);

        // Abort after 40 samples; clr also wins over the sample offered alongside it.
        clear_stats();
        for (int i = 0; i < 40; i++) send(5, 9);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        for (int i = 0; i < CELL_PIX; i++) send(1, 1);
        i_valid = 1'b0;
        wait_drained();
        chk("t5_bin1", got_val[1], 64);
        chk("t5_bin5", got_val[5], 0);

        // Asynchronous reset in the middle of a drain.
        clear_stats();
        for (int i = 0; i < CELL_PIX; i++) send(6, 2);
        i_valid = 1'b0;
        wait_bin(5);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("t6_rst_o_valid", o_valid, 0);
        chk("t6_rst_i_ready", i_ready, 1);
        chk("t6_rst_bin_val", o_bin_val, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_stats();
        for (int i = 0; i < CELL_PIX; i++) send(3, 7);
        i_valid = 1'b0;
        wait_drained();
        chk("t6_bin3", got_val[3], 448);
        chk("t6_bin6", got_val[6], 0);
        chk("t6_bins_moved", drain_cnt, 9);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
